button_gesture_encoder: RTL and testbench
=========================================

# button_gesture_encoder

Front-end for the turn-input selection FSM: converts the four raw board push-buttons into the single-cycle `control[3:0]` events that FSM consumes. Each bit is synchronized and debounced. A complete press/release gesture is then reported once, on the final release, as the OR of every button held during the gesture. A single button yields a one-hot code; the four-button chord yields `4'b1111`, the confirm code. `control` is all-zero in every cycle except the one-cycle event, so the downstream FSM sees "no input" by default.

## Interface
- `DB_CYCLES`, default 250000: consecutive stable cycles required before a debounced bit changes; minimum 2.
- `TIMEOUT_CYCLES`, default 50000000: maximum gesture length in cycles; used only with `BTN_GESTURE_TIMEOUT_EN`.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `btn_raw`, input, 4: asynchronous raw buttons, active-high; bit 3 is button 0, bit 2 is button 1.
- `control`, output, 4: gesture code; nonzero only while `control_valid` is 1.
- `control_valid`, output, 1: one-cycle pulse marking a gesture event.
- `gesture_active`, output, 1: high while any debounced button is held in a gesture.
- `gesture_abort`, output, 1: one-cycle timeout pulse; tied to 0 without the macro.

## Operation
- **Synchronizer:** 2-flop per bit; `sync[i]` is `btn_raw[i]` delayed by 2 cycles.
- **Debounce:** one counter per bit.
  - While `sync[i] == deb[i]`, the counter is held at 0.
  - Otherwise it increments each cycle.
  - When the counter reaches `DB_CYCLES-1` while the bit still differs, `deb[i] <= sync[i]` and the counter clears.
  - Any intermediate match restarts the count.
- **Gesture FSM:**
  - IDLE: when `deb != 0`, go to COLLECT with `acc <= deb` and `gesture_active <= 1`.
  - COLLECT, `deb != 0`: `acc <= acc | deb`; stay in COLLECT.
  - COLLECT, `deb == 0`: emit `control <= acc` and `control_valid <= 1`; `acc <= 0`; `gesture_active <= 0`; go to IDLE.
  - ABORT (macro only): hold `control = 0`; when `deb == 0`, go to IDLE with no event.
- **Outputs:** all registered. `control` and `control_valid` return to 0 in the cycle after a pulse.
- **Boundary conditions:**
  - Press and release of different bits inside the same gesture: all bits accumulate. Emission happens only when every bit is released simultaneously in `deb`.
  - A new press in the cycle after an emission starts a fresh gesture from IDLE; nothing is lost and nothing merges.
  - Glitches shorter than `DB_CYCLES` never change `deb` and produce no event.
- **Reset:** clears sync flops, debounce counters, `deb`, `acc`, the timeout timer and every output to 0; state goes to IDLE. A button still held after reset debounces as a new press.

## Timing
- Raw edge to `deb` change: 2 + `DB_CYCLES` cycles for a clean edge.
- `deb` reaching 0 at edge t gives `control_valid` = 1 during cycle t+1.
- Press-to-`gesture_active` latency: `deb` rising at edge t gives `gesture_active` = 1 from edge t+1.
- Exactly one `control_valid` pulse per completed gesture; never back-to-back.
- Throughput: at most one event per 2·`DB_CYCLES` cycles, bounded by the debounce.

## Configuration
- **`BTN_GESTURE_TIMEOUT_EN` defined:**
  - A timer counts cycles spent in COLLECT.
  - On reaching `TIMEOUT_CYCLES`: pulse `gesture_abort` for 1 cycle, clear `acc` and `gesture_active`, go to ABORT.
  - The release that follows produces no `control_valid`.
- **Undefined:** no timer, no ABORT state; `gesture_abort` is constant 0 and gestures may last indefinitely.

## Test plan
1. **Single press:** `DB_CYCLES=4`; `btn_raw=4'b1000` for 12 cycles, then 0 -> exactly one pulse `control=4'b1000`, 7 cycles after the falling raw edge (2 sync + 4 debounce + 1 output register).
2. **Bounce:** `btn_raw[0]` toggles every 2 cycles for 12 cycles, then holds 1 for 10 cycles and releases cleanly -> one pulse `control=4'b0001`, none during the bounce.
3. **Staggered chord:** press bits 3, 2, 1, 0 two hundred cycles apart, then release them in reverse order, also staggered -> a single pulse `control=4'b1111` after the last release; `gesture_active` high throughout.
4. **Short glitch:** `btn_raw=4'b0100` for 3 cycles with `DB_CYCLES=4` -> `deb`, `control`, `control_valid` and `gesture_active` all stay 0.
5. **Reset mid-gesture:** hold `4'b0100`, assert `rst` for 1 cycle during COLLECT, keep holding 10 cycles, then release -> outputs 0 while in reset, then one pulse `control=4'b0100`.
6. **Timeout (macro defined):** `TIMEOUT_CYCLES=20`; hold `4'b1000` for 40 cycles, then release -> `gesture_abort` pulses once; no `control_valid` on release.

Source files
------------

// File: rtl/button_gesture_encoder_if.sv
// Button-side bundle of the gesture encoder: raw buttons in, gesture events out.
interface button_gesture_encoder_if;
  logic [3:0] btn_raw;
  logic [3:0] control;
  logic       control_valid;
  logic       gesture_active;
  logic       gesture_abort;

  modport master (
    output btn_raw,
    input  control,
    input  control_valid,
    input  gesture_active,
    input  gesture_abort
  );

  modport slave (
    input  btn_raw,
    output control,
    output control_valid,
    output gesture_active,
    output gesture_abort
  );
endinterface

// File: rtl/button_gesture_encoder.sv
// Synchronizes and debounces four push-buttons and reports each press/release gesture once, on release.
// Optional gesture timeout is enabled by defining BTN_GESTURE_TIMEOUT_EN.
module button_gesture_encoder #(
  parameter int unsigned DB_CYCLES      = 250000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input logic                      clk,
  input logic                      rst,
  button_gesture_encoder_if.slave  bus
);

  localparam int unsigned NB    = 4;
  localparam int unsigned CNT_W = $clog2(DB_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1
`ifdef BTN_GESTURE_TIMEOUT_EN
    ,
    S_ABORT   = 2'd2
`endif
  } state_t;

  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    r_deb;
  logic [CNT_W-1:0] r_cnt [NB];

  state_t  r_state;
  state_t  w_state_nxt;
  logic [NB-1:0] r_acc;
  logic [NB-1:0] w_acc_nxt;
  logic [NB-1:0] r_control;
  logic [NB-1:0] w_control_nxt;
  logic    r_control_valid;
  logic    w_control_valid_nxt;
  logic    r_gesture_active;
  logic    w_gesture_active_nxt;

`ifdef BTN_GESTURE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_timer;
  logic [TO_W-1:0] w_timer_nxt;
  logic            r_gesture_abort;
  logic            w_gesture_abort_nxt;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Two-flop synchronizer and per-bit debounce counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Gesture FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_acc            <= '0;
      r_control        <= '0;
      r_control_valid  <= 1'b0;
      r_gesture_active <= 1'b0;
`ifdef BTN_GESTURE_TIMEOUT_EN
      r_timer          <= '0;
      r_gesture_abort  <= 1'b0;
`endif
    end else begin
      r_state          <= w_state_nxt;
      r_acc            <= w_acc_nxt;
      r_control        <= w_control_nxt;
      r_control_valid  <= w_control_valid_nxt;
      r_gesture_active <= w_gesture_active_nxt;
`ifdef BTN_GESTURE_TIMEOUT_EN
      r_timer          <= w_timer_nxt;
      r_gesture_abort  <= w_gesture_abort_nxt;
`endif
    end
  end

  // Next state: accumulate held buttons, emit once everything is released
  always_comb begin
    w_state_nxt          = r_state;
    w_acc_nxt            = r_acc;
    w_control_nxt        = '0;
    w_control_valid_nxt  = 1'b0;
    w_gesture_active_nxt = r_gesture_active;
`ifdef BTN_GESTURE_TIMEOUT_EN
    w_timer_nxt          = '0;
    w_gesture_abort_nxt  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_deb != '0) begin
          w_state_nxt          = S_COLLECT;
          w_acc_nxt            = r_deb;
          w_gesture_active_nxt = 1'b1;
        end
      end
      S_COLLECT: begin
        if (r_deb == '0) begin
          w_state_nxt          = S_IDLE;
          w_control_nxt        = r_acc;
          w_control_valid_nxt  = 1'b1;
          w_acc_nxt            = '0;
          w_gesture_active_nxt = 1'b0;
        end
`ifdef BTN_GESTURE_TIMEOUT_EN
        else if (r_timer == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt          = S_ABORT;
          w_gesture_abort_nxt  = 1'b1;
          w_acc_nxt            = '0;
          w_gesture_active_nxt = 1'b0;
        end
`endif
        else begin
          w_acc_nxt = r_acc | r_deb;
`ifdef BTN_GESTURE_TIMEOUT_EN
          w_timer_nxt = r_timer + TO_W'(1);
`endif
        end
      end
`ifdef BTN_GESTURE_TIMEOUT_EN
      S_ABORT: begin
        if (r_deb == '0) w_state_nxt = S_IDLE;
      end
`endif
      default: begin
        w_state_nxt          = S_IDLE;
        w_acc_nxt            = '0;
        w_gesture_active_nxt = 1'b0;
      end
    endcase
  end

  assign bus.control        = r_control;
  assign bus.control_valid  = r_control_valid;
  assign bus.gesture_active = r_gesture_active;
`ifdef BTN_GESTURE_TIMEOUT_EN
  assign bus.gesture_abort  = r_gesture_abort;
`else
  assign bus.gesture_abort  = 1'b0;
`endif

endmodule

// File: tb/tb_button_gesture_encoder.sv
// Directed bench for button_gesture_encoder with DB_CYCLES=4 and TIMEOUT_CYCLES=20.
module tb_button_gesture_encoder;

  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_gesture_encoder_if bus ();

  button_gesture_encoder #(
    .DB_CYCLES      (DB),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         pulses      = 0;
  int         aborts      = 0;
  int         b2b         = 0;
  int         stray       = 0;
  logic [3:0] last_ctrl   = '0;
  int         last_cyc    = 0;
  logic       prev_valid  = 1'b0;
  logic       seen_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (bus.control_valid) begin
      pulses++;
      last_ctrl = bus.control;
      last_cyc  = cyc;
      if (prev_valid) b2b++;
    end else if (bus.control != 4'b0000) begin
      stray++;
    end
    if (bus.gesture_abort) aborts++;
    if (bus.gesture_active) seen_active = 1'b1;
    prev_valid = bus.control_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p0;
  int a0;
  int t0;
  logic [3:0] btn;

  initial begin
    bus.btn_raw = 4'b0000;
    rst = 1'b1;
    tick(3);
    check("rst_control", 32'(bus.control), 32'h0);
    check("rst_valid",   32'(bus.control_valid), 32'h0);
    check("rst_active",  32'(bus.gesture_active), 32'h0);
    check("rst_abort",   32'(bus.gesture_abort), 32'h0);
    rst = 1'b0;
    tick(2);

    // Single press: deb rises 6 edges after the raw edge, active one edge later
    bus.btn_raw = 4'b1000;
    tick(6);
    check("t1_active_early", 32'(bus.gesture_active), 32'h0);
    tick(1);
    check("t1_active_on", 32'(bus.gesture_active), 32'h1);
    tick(5);
    p0 = pulses;
    bus.btn_raw = 4'b0000;
    t0 = cyc;
    tick(10);
    check("t1_pulses",  32'(pulses - p0), 32'd1);
    check("t1_code",    32'(last_ctrl), 32'b1000);
    check("t1_latency", 32'(last_cyc - t0), 32'd7);
    check("t1_active_off", 32'(bus.gesture_active), 32'h0);

    // Bounce on bit 0 never settles long enough, then a clean press
    seen_active = 1'b0;
    p0 = pulses;
    for (int k = 0; k < 12; k++) begin
      bus.btn_raw = ((k % 4) < 2) ? 4'b0001 : 4'b0000;
      tick(1);
    end
    check("t2_bounce_pulses", 32'(pulses - p0), 32'd0);
    check("t2_bounce_active", 32'(seen_active), 32'h0);
    bus.btn_raw = 4'b0001;
    tick(10);
    bus.btn_raw = 4'b0000;
    tick(10);
    check("t2_pulses", 32'(pulses - p0), 32'd1);
    check("t2_code",   32'(last_ctrl), 32'b0001);

    // Staggered four-button chord, released in reverse order
    p0 = pulses;
    btn = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      btn[3-k] = 1'b1;
      bus.btn_raw = btn;
      tick(200);
      check($sformatf("t3_press%0d_active", k), 32'(bus.gesture_active), 32'h1);
    end
    for (int k = 0; k < 4; k++) begin
      btn[k] = 1'b0;
      bus.btn_raw = btn;
      if (k < 3) begin
        tick(200);
        check($sformatf("t3_rel%0d_active", k), 32'(bus.gesture_active), 32'h1);
        check($sformatf("t3_rel%0d_pulses", k), 32'(pulses - p0), 32'd0);
      end
    end
    tick(10);
    check("t3_pulses", 32'(pulses - p0), 32'd1);
    check("t3_code",   32'(last_ctrl), 32'b1111);
    check("t3_active_off", 32'(bus.gesture_active), 32'h0);

    // Overlapping presses of different bits accumulate into one code
    p0 = pulses;
    bus.btn_raw = 4'b1000;
    tick(20);
    bus.btn_raw = 4'b1010;
    tick(20);
    bus.btn_raw = 4'b0010;
    tick(20);
    check("t3b_mid_pulses", 32'(pulses - p0), 32'd0);
    check("t3b_mid_active", 32'(bus.gesture_active), 32'h1);
    bus.btn_raw = 4'b0000;
    tick(10);
    check("t3b_pulses", 32'(pulses - p0), 32'd1);
    check("t3b_code",   32'(last_ctrl), 32'b1010);

    // A glitch one cycle shorter than the debounce window is ignored
    seen_active = 1'b0;
    p0 = pulses;
    bus.btn_raw = 4'b0100;
    tick(3);
    bus.btn_raw = 4'b0000;
    tick(12);
    check("t4_active", 32'(seen_active), 32'h0);
    check("t4_pulses", 32'(pulses - p0), 32'd0);

    // Reset during COLLECT, button still held afterwards
    p0 = pulses;
    bus.btn_raw = 4'b0100;
    tick(8);
    check("t5_active_pre", 32'(bus.gesture_active), 32'h1);
    rst = 1'b1;
    tick(1);
    check("t5_rst_active",  32'(bus.gesture_active), 32'h0);
    check("t5_rst_valid",   32'(bus.control_valid), 32'h0);
    check("t5_rst_control", 32'(bus.control), 32'h0);
    rst = 1'b0;
    tick(10);
    check("t5_rst_pulses", 32'(pulses - p0), 32'd0);
    check("t5_active_re",  32'(bus.gesture_active), 32'h1);
    bus.btn_raw = 4'b0000;
    tick(10);
    check("t5_pulses", 32'(pulses - p0), 32'd1);
    check("t5_code",   32'(last_ctrl), 32'b0100);

`ifdef BTN_GESTURE_TIMEOUT_EN
    // Gesture held past the timeout aborts and its release is silent
    p0 = pulses;
    a0 = aborts;
    bus.btn_raw = 4'b1000;
    tick(40);
    check("t6_active_after_abort", 32'(bus.gesture_active), 32'h0);
    bus.btn_raw = 4'b0000;
    tick(10);
    check("t6_aborts", 32'(aborts - a0), 32'd1);
    check("t6_pulses", 32'(pulses - p0), 32'd0);
`else
    a0 = 0;
    check("abort_never", 32'(aborts), 32'd0);
`endif

    check("no_back_to_back", 32'(b2b), 32'd0);
    check("no_stray_control", 32'(stray), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
